// File: rtl/demux_pkg.sv
// Shared defaults and lane-count helper for the demux slice.
package demux_pkg;

  localparam int DEMUX_DATA_W = 1;
  localparam int DEMUX_SEL_W  = 2;
  localparam int DEMUX_CNT_W  = 8;

  function automatic int lane_count(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/demux_sat_cnt.sv
// Single saturating up-counter with increment enable and async active-low reset.
module demux_sat_cnt #(
  parameter int CNT_W = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/demux.sv
// 1-to-NOUT demultiplexer with registered copy and optional per-lane activity
// counters (built only when DEMUX_ACT_CNT_EN is defined).
module demux
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEMUX_DATA_W,
  parameter  int SEL_W  = DEMUX_SEL_W,
  parameter  int CNT_W  = DEMUX_CNT_W,
  localparam int NOUT   = lane_count(SEL_W)
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      D,
  input  logic [SEL_W-1:0]       S,
  output logic [NOUT*DATA_W-1:0] Y,
  output logic [NOUT*DATA_W-1:0] Y_q,
  output logic [NOUT*CNT_W-1:0]  act_cnt
);

  logic [NOUT*DATA_W-1:0] w_y;
  logic [NOUT*DATA_W-1:0] r_y_q;

  // An if on an unknown select is not taken, so X/Z on S leaves every lane zero.
  always_comb begin
    w_y = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (S == SEL_W'(k))
        w_y[k*DATA_W +: DATA_W] = D;
    end
  end

  assign Y = w_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_y_q <= '0;
    else
      r_y_q <= w_y;
  end

  assign Y_q = r_y_q;

`ifdef DEMUX_ACT_CNT_EN
  logic w_active;
  assign w_active = |D;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_cnt
    demux_sat_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_active && (S == SEL_W'(gi))),
      .o_cnt (act_cnt[gi*CNT_W +: CNT_W])
    );
  end
`else
  assign act_cnt = '0;
`endif

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux (default parameters); counter expectations
// follow whether DEMUX_ACT_CNT_EN is defined for the build.
`timescale 1ns/1ps
module tb_demux;

  localparam int NOUT  = 4;
  localparam int MAXC  = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [0:0]  D = 1'b0;
  logic [1:0]  S = 2'b00;
  logic [3:0]  Y;
  logic [3:0]  Y_q;
  logic [31:0] act_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state: expected Y_q and per-lane counts.
  logic [3:0] m_yq;
  int         m_cnt [NOUT];

  demux dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D       (D),
    .S       (S),
    .Y       (Y),
    .Y_q     (Y_q),
    .act_cnt (act_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_y(input logic [0:0] d, input logic [1:0] s);
    logic [3:0] v;
    v = 4'b0000;
    v[s] = d[0];
    return v;
  endfunction

  function automatic logic [31:0] exp_act();
    logic [31:0] v;
    v = '0;
`ifdef DEMUX_ACT_CNT_EN
    for (int i = 0; i < NOUT; i++) v[i*8 +: 8] = 8'(m_cnt[i]);
`endif
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq <= 4'b0000;
      for (int i = 0; i < NOUT; i++) m_cnt[i] <= 0;
    end else begin
      m_yq <= exp_y(D, S);
      if (D != 0 && m_cnt[S] < MAXC) m_cnt[S] <= m_cnt[S] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [0:0] d, input logic [1:0] s);
    @(negedge clk);
    #1;
    D = d;
    S = s;
  endtask

  initial begin
    logic [0:0] rd;
    logic [1:0] rs;
    int         fails_before;

    #1 rst_n = 1'b0;
    #1;
    check("reset_yq", {28'd0, Y_q}, 32'd0);
    check("reset_cnt", act_cnt, 32'd0);
    chk_en = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check("cyc_y", {28'd0, Y}, {28'd0, exp_y(D, S)});
          check("cyc_yq", {28'd0, Y_q}, {28'd0, m_yq});
          check("cyc_cnt", act_cnt, exp_act());
        end
      end
    join_none

    @(negedge clk); #1 rst_n = 1'b1;

    drive(1'b1, 2'b10);
    #2 check("y_d1_s2", {28'd0, Y}, 32'h4);
    $display("txn D=1 S=2 Y=%b", Y);
    drive(1'b0, 2'b10);
    #2 check("y_d0_s2", {28'd0, Y}, 32'h0);
    $display("txn D=0 S=2 Y=%b", Y);

    fails_before = chk_cnt - pass_cnt;
    for (int i = 0; i < 99; i++) begin
      rd = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      drive(rd, rs);
      #2 check("rand_y", {28'd0, Y}, {28'd0, exp_y(rd, rs)});
      $display("txn rand %0d D=%0d S=%0d Y=%b", i, rd, rs, Y);
      if (chk_cnt - pass_cnt != fails_before) begin
        $display("FAIL rand_stop: random routing mismatch, stopping");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "random routing mismatch");
      end
    end

    drive(1'b0, 2'b00);
    drive(1'b1, 2'b11);
    #2 check("yq_not_before", {28'd0, Y_q}, 32'h0);
    @(posedge clk); #1;
    check("yq_latency", {28'd0, Y_q}, 32'h8);
    $display("txn D=1 S=3 Y_q=%b", Y_q);

    @(negedge clk); #1 rst_n = 1'b0; D = 1'b1; S = 2'b00;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
`ifdef DEMUX_ACT_CNT_EN
    check("sat_cnt", act_cnt, 32'h0000_00FF);
`else
    check("cnt_off", act_cnt, 32'h0);
`endif
    $display("txn 300 cycles D=1 S=0 act_cnt=%h", act_cnt);

    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_yq", {28'd0, Y_q}, 32'h0);
    check("rst_cnt", act_cnt, 32'h0);
    check("rst_y_live", {28'd0, Y}, 32'h1);
    S = 2'b10;
    #1 check("rst_y_follow", {28'd0, Y}, 32'h4);
    $display("txn reset mid-op Y=%b Y_q=%b act_cnt=%h", Y, Y_q, act_cnt);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("resume_yq", {28'd0, Y_q}, 32'h4);
`ifdef DEMUX_ACT_CNT_EN
    check("resume_cnt", act_cnt, 32'h0001_0000);
`else
    check("resume_cnt", act_cnt, 32'h0);
`endif
    $display("txn resume Y_q=%b act_cnt=%h", Y_q, act_cnt);

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
